// File: rtl/vc_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vc_arbiter_pkg
// Shared definitions for the two-VC arbiter slice.
//   arb_state_t        : arbitration FSM encoding (IDLE, GNT_VC0, GNT_VC1, PAUSED)
//   VC_DATA_WIDTH_DEF  : default width of every data word
// -----------------------------------------------------------------------------
package vc_arbiter_pkg;

   localparam int VC_DATA_WIDTH_DEF = 6;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_VC0 = 2'd1,
      GNT_VC1 = 2'd2,
      PAUSED  = 2'd3
   } arb_state_t;

endpackage : vc_arbiter_pkg

// File: rtl/vc_route_reg.sv
// -----------------------------------------------------------------------------
// vc_route_reg
// Output register for the arbiter plus destination decode. A word granted in
// cycle N is presented on data_out in cycle N+1 together with exactly one
// push strobe chosen by bit [DATA_WIDTH-2] of the word.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   vld_p0              : a word is granted this cycle
//   vc_p0               : VC the granted word came from
//   data_p0             : granted word
//   data_out, active_vc : registered word and its VC (hold when nothing granted)
//   push_d0, push_d1    : one-cycle write strobes to destination D0 / D1
// -----------------------------------------------------------------------------
module vc_route_reg
   import vc_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = VC_DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  vld_p0,
   input  logic                  vc_p0,
   input  logic [DATA_WIDTH-1:0] data_p0,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  push_d0,
   output logic                  push_d1,
   output logic                  active_vc
);

   logic [DATA_WIDTH-1:0] data_p1;
   logic                  vc_p1;
   logic                  push0_p1;
   logic                  push1_p1;

   // Destination D1 is selected when the routing bit of the word is set.
   function automatic logic dest_is_d1(input logic [DATA_WIDTH-1:0] word);
      return word[DATA_WIDTH-2];
   endfunction

   // ---- stage p0 -> p1: capture granted word, decode destination ----
   // Data is reset too so that a word in flight at reset is discarded and
   // data_out reads zero afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_p1  <= '0;
         vc_p1    <= 1'b0;
         push0_p1 <= 1'b0;
         push1_p1 <= 1'b0;
      end else begin
         push0_p1 <= vld_p0 && !dest_is_d1(data_p0);
         push1_p1 <= vld_p0 &&  dest_is_d1(data_p0);
         if (vld_p0) begin
            data_p1 <= data_p0;
            vc_p1   <= vc_p0;
         end
      end
   end

   assign data_out  = data_p1;
   assign active_vc = vc_p1;
   assign push_d0   = push0_p1;
   assign push_d1   = push1_p1;

endmodule : vc_route_reg

// File: rtl/vc_arbiter.sv
// -----------------------------------------------------------------------------
// vc_arbiter
// Two virtual-channel arbiter: pops at most one word per cycle from the VC0 /
// VC1 first-word-fall-through FIFOs and forwards it, one cycle later, to
// destination FIFO D0 or D1. VC0 has priority; any destination pause blocks
// all grants.
// Optional feature (macro VC_ARB_STARVE_GUARD_EN): after BURST_MAX consecutive
// VC0 grants while VC1 is waiting, the next grant goes to VC1.
// Ports:
//   clk, reset                       : clock, asynchronous active-high reset
//   empty_fifo_VC0/1, data_out_VC0/1 : VC FIFO empty flags and head words
//   pause_d0/1                       : almost-full from destinations
//   pop_VC0_fifo/pop_VC1_fifo        : combinational pop strobes
//   data_out, push_d0/1, active_vc   : registered forwarded word, strobes, VC
// -----------------------------------------------------------------------------
module vc_arbiter
   import vc_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = VC_DATA_WIDTH_DEF,
   parameter int BURST_MAX  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  empty_fifo_VC0,
   input  logic                  empty_fifo_VC1,
   input  logic [DATA_WIDTH-1:0] data_out_VC0,
   input  logic [DATA_WIDTH-1:0] data_out_VC1,
   input  logic                  pause_d0,
   input  logic                  pause_d1,
   output logic                  pop_VC0_fifo,
   output logic                  pop_VC1_fifo,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  push_d0,
   output logic                  push_d1,
   output logic                  active_vc
);

   arb_state_t            state;
   logic                  blocked;
   logic                  force_vc1;
   logic                  grant_vc0;
   logic                  grant_vc1;
   logic                  vld_p0;
   logic                  vc_p0;
   logic [DATA_WIDTH-1:0] data_p0;

   // ---- stage p0: grant decision (combinational) ----
   assign blocked   = pause_d0 | pause_d1;
   // Grants are gated by the empty flags directly, so a pop can never reach
   // an empty FIFO, and an empty/pause change lands in the same cycle.
   assign grant_vc0 = !reset && !blocked && !empty_fifo_VC0 && !force_vc1;
   assign grant_vc1 = !reset && !blocked && !empty_fifo_VC1 &&
                      (empty_fifo_VC0 || force_vc1);

   assign pop_VC0_fifo = grant_vc0;
   assign pop_VC1_fifo = grant_vc1;

   assign vld_p0  = grant_vc0 | grant_vc1;
   assign vc_p0   = grant_vc1;
   assign data_p0 = grant_vc1 ? data_out_VC1 : data_out_VC0;

`ifdef VC_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(BURST_MAX + 1);

   logic [CNT_W-1:0] burst_cnt;

   // Counts VC0 grants taken while VC1 is waiting. Once it reaches BURST_MAX
   // the VC0 grant is withheld, so the counter never runs past BURST_MAX.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         burst_cnt <= '0;
      end else if (empty_fifo_VC1 || grant_vc1) begin
         burst_cnt <= '0;
      end else if (grant_vc0) begin
         burst_cnt <= burst_cnt + CNT_W'(1);
      end
   end

   // Qualified with VC1 nonempty: the counter clears one cycle after VC1
   // drains, and VC0 must not be held off in that cycle.
   assign force_vc1 = (burst_cnt == CNT_W'(BURST_MAX)) && !empty_fifo_VC1;
`else
   logic unused_burst_max;

   assign force_vc1        = 1'b0;
   assign unused_burst_max = (BURST_MAX != 0);
`endif

   // ---- stage p0 -> p1: FSM records what happened this cycle ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else if (grant_vc0) begin
         state <= GNT_VC0;
      end else if (grant_vc1) begin
         state <= GNT_VC1;
      end else if (blocked && (!empty_fifo_VC0 || !empty_fifo_VC1)) begin
         state <= PAUSED;
      end else begin
         state <= IDLE;
      end
   end

   // The state register is kept for debug visibility; no output decodes it.
   logic unused_state;
   assign unused_state = ^state;

   vc_route_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_route_reg (
      .clk       (clk),
      .reset     (reset),
      .vld_p0    (vld_p0),
      .vc_p0     (vc_p0),
      .data_p0   (data_p0),
      .data_out  (data_out),
      .push_d0   (push_d0),
      .push_d1   (push_d1),
      .active_vc (active_vc)
   );

endmodule : vc_arbiter

// File: tb/tb_vc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vc_arbiter
// Self-checking bench for vc_arbiter. The VC FIFOs are modelled as queues;
// a queue-level reference decides each cycle's grant from the arbitration
// rules and predicts the registered output one cycle later.
// Works with and without VC_ARB_STARVE_GUARD_EN defined.
// -----------------------------------------------------------------------------
module tb_vc_arbiter;

   localparam int DW = 6;
   localparam int BM = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          empty_fifo_VC0, empty_fifo_VC1;
   logic [DW-1:0] data_out_VC0, data_out_VC1;
   logic          pause_d0, pause_d1;
   logic          pop_VC0_fifo, pop_VC1_fifo;
   logic [DW-1:0] data_out;
   logic          push_d0, push_d1, active_vc;

   vc_arbiter #(
      .DATA_WIDTH (DW),
      .BURST_MAX  (BM)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .empty_fifo_VC0 (empty_fifo_VC0),
      .empty_fifo_VC1 (empty_fifo_VC1),
      .data_out_VC0   (data_out_VC0),
      .data_out_VC1   (data_out_VC1),
      .pause_d0       (pause_d0),
      .pause_d1       (pause_d1),
      .pop_VC0_fifo   (pop_VC0_fifo),
      .pop_VC1_fifo   (pop_VC1_fifo),
      .data_out       (data_out),
      .push_d0        (push_d0),
      .push_d1        (push_d1),
      .active_vc      (active_vc)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   int            m_burst = 0;   // consecutive VC0 grants while VC1 waited
   logic [DW-1:0] exp_data = '0;
   logic          exp_vc = 1'b0, exp_push0 = 1'b0, exp_push1 = 1'b0;
   int            g_log[$];      // granted VC per grant, in order

   task automatic drive_inputs(input bit pa0, input bit pa1);
      empty_fifo_VC0 = (q0.size() == 0);
      empty_fifo_VC1 = (q1.size() == 0);
      data_out_VC0   = empty_fifo_VC0 ? DW'($urandom) : q0[0];
      data_out_VC1   = empty_fifo_VC1 ? DW'($urandom) : q1[0];
      pause_d0       = pa0;
      pause_d1       = pa1;
   endtask

   task automatic model_clear();
      exp_data  = '0;
      exp_vc    = 1'b0;
      exp_push0 = 1'b0;
      exp_push1 = 1'b0;
      m_burst   = 0;
   endtask

   // One clock cycle: predict the grant, check pops, clock, check outputs.
   task automatic step(input bit pa0, input bit pa1);
      bit            g0, g1, force1, vc1_waiting;
      logic [DW-1:0] w;
      drive_inputs(pa0, pa1);
      #1;
      force1 = 1'b0;
`ifdef VC_ARB_STARVE_GUARD_EN
      force1 = (m_burst >= BM) && (q1.size() > 0);
`endif
      g0 = 1'b0;
      g1 = 1'b0;
      if (!(pa0 || pa1)) begin
         if (q0.size() > 0 && !force1) g0 = 1'b1;
         else if (q1.size() > 0)       g1 = 1'b1;
      end
      n_checks++;
      if ({pop_VC0_fifo, pop_VC1_fifo} !== {g0, g1}) begin
         n_fail++;
         $display("FAIL pop_grant t=%0t: pop0/pop1 got %b%b expected %b%b",
                  $time, pop_VC0_fifo, pop_VC1_fifo, g0, g1);
      end
      vc1_waiting = (q1.size() > 0);
      @(posedge clk);
      if (g0 || g1) begin
         w = g1 ? q1.pop_front() : q0.pop_front();
         exp_data  = w;
         exp_vc    = g1;
         exp_push0 = !w[DW-2];
         exp_push1 =  w[DW-2];
         g_log.push_back(g1 ? 1 : 0);
      end else begin
         exp_push0 = 1'b0;
         exp_push1 = 1'b0;
      end
      if (!vc1_waiting || g1) m_burst = 0;
      else if (g0)            m_burst = m_burst + 1;
      #1;
      n_checks++;
      if ({data_out, active_vc} !== {exp_data, exp_vc}) begin
         n_fail++;
         $display("FAIL out_word t=%0t: data/vc got %h/%b expected %h/%b",
                  $time, data_out, active_vc, exp_data, exp_vc);
      end
      n_checks++;
      if ({push_d0, push_d1} !== {exp_push0, exp_push1}) begin
         n_fail++;
         $display("FAIL push t=%0t: push_d0/d1 got %b%b expected %b%b",
                  $time, push_d0, push_d1, exp_push0, exp_push1);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      q0.push_back(6'h2A);
      q1.push_back(6'h13);
      drive_inputs(0, 0);
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({data_out, active_vc, push_d0, push_d1} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got data=%h vc=%b push=%b%b expected all 0",
                  data_out, active_vc, push_d0, push_d1);
      end
      n_checks++;
      if ({pop_VC0_fifo, pop_VC1_fifo} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_pops: got %b%b expected 00", pop_VC0_fifo, pop_VC1_fifo);
      end
      q0.delete();
      q1.delete();
      drive_inputs(0, 0);
      reset = 1'b0;
      model_clear();
   endtask

   task automatic test_single_vc0();
      q0.push_back(6'h05);
      step(0, 0);
      n_checks++;
      if ({data_out, push_d0, push_d1, active_vc} !== {6'h05, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL single_vc0: got data=%h push=%b%b vc=%b expected 05 10 0",
                  data_out, push_d0, push_d1, active_vc);
      end
      step(0, 0);
   endtask

   task automatic test_route_d1();
      q0.push_back(6'h11);
      step(0, 0);
      n_checks++;
      if ({push_d1, push_d0, active_vc} !== 3'b100) begin
         n_fail++;
         $display("FAIL route_d1: got push_d1=%b push_d0=%b vc=%b expected 1 0 0",
                  push_d1, push_d0, active_vc);
      end
      step(0, 0);
   endtask

   task automatic test_burst();
      int exp_seq[$];
      int a, b, run, guard;
      bit seq_ok;
      g_log.delete();
      for (int i = 0; i < 10; i++) begin
         q0.push_back(DW'($urandom));
         q1.push_back(DW'($urandom));
      end
      guard = 0;
      while ((q0.size() > 0 || q1.size() > 0) && guard < 40) begin
         step(0, 0);
         guard++;
      end
      step(0, 0);
      a = 10; b = 10; run = 0;
      while (a > 0 || b > 0) begin
`ifdef VC_ARB_STARVE_GUARD_EN
         if (b > 0 && (run == BM || a == 0)) begin
            exp_seq.push_back(1); b--; run = 0;
         end else begin
            exp_seq.push_back(0); a--; run = (b > 0) ? run + 1 : 0;
         end
`else
         if (a > 0) begin exp_seq.push_back(0); a--; end
         else       begin exp_seq.push_back(1); b--; end
`endif
      end
      n_checks++;
      if (g_log.size() != exp_seq.size()) begin
         n_fail++;
         $display("FAIL burst_count: got %0d grants expected %0d", g_log.size(), exp_seq.size());
      end
      seq_ok = (g_log.size() == exp_seq.size());
      for (int i = 0; i < exp_seq.size() && i < g_log.size(); i++)
         if (g_log[i] != exp_seq[i]) seq_ok = 1'b0;
      n_checks++;
      if (!seq_ok) begin
         n_fail++;
         $display("FAIL burst_pattern: got %p expected %p", g_log, exp_seq);
      end
   endtask

   task automatic test_pause();
      g_log.delete();
      for (int i = 0; i < 3; i++) begin
         q0.push_back(DW'($urandom));
         q1.push_back(DW'($urandom));
      end
      step(0, 0);
      repeat (3) step(0, 1);
      for (int i = 0; i < 8; i++) step(0, 0);
      n_checks++;
      if (g_log.size() != 6 || q0.size() != 0 || q1.size() != 0) begin
         n_fail++;
         $display("FAIL pause_words: got %0d words forwarded expected 6", g_log.size());
      end
   endtask

   task automatic test_reset_midflight();
      logic [DW-1:0] w;
      q0.push_back(6'h07);
      drive_inputs(0, 0);
      #1;
      n_checks++;
      if (pop_VC0_fifo !== 1'b1) begin
         n_fail++;
         $display("FAIL midflight_pop: got %b expected 1", pop_VC0_fifo);
      end
      @(posedge clk);
      w = q0.pop_front();
      q1.push_back(6'h03);
      drive_inputs(0, 0);
      #1 reset = 1'b1;
      #1;
      n_checks++;
      if ({data_out, push_d0, push_d1, pop_VC0_fifo, pop_VC1_fifo} !== '0) begin
         n_fail++;
         $display("FAIL midflight_reset: got data=%h push=%b%b pop=%b%b expected all 0 (word %h)",
                  data_out, push_d0, push_d1, pop_VC0_fifo, pop_VC1_fifo, w);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({push_d0, push_d1, pop_VC0_fifo, pop_VC1_fifo} !== 4'b0000) begin
         n_fail++;
         $display("FAIL midflight_hold: got push=%b%b pop=%b%b expected 0000",
                  push_d0, push_d1, pop_VC0_fifo, pop_VC1_fifo);
      end
      reset = 1'b0;
      model_clear();
      step(0, 0);
      step(0, 0);
   endtask

   task automatic test_empty_swap();
      q0.push_back(6'h0C);
      step(0, 0);
      q1.push_back(6'h1E);
      step(0, 0);
      step(1, 0);
      q1.push_back(6'h21);
      step(0, 0);
      step(0, 0);
   endtask

   task automatic test_random();
      int guard;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(1) == 1 && q0.size() < 8) q0.push_back(DW'($urandom));
         if ($urandom_range(2) == 0 && q1.size() < 8) q1.push_back(DW'($urandom));
         step($urandom_range(4) == 0, $urandom_range(4) == 0);
      end
      guard = 0;
      while ((q0.size() > 0 || q1.size() > 0) && guard < 40) begin
         step(0, 0);
         guard++;
      end
      n_checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_fail++;
         $display("FAIL random_drain: got %0d/%0d words left expected 0/0", q0.size(), q1.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_vc0();
      test_route_d1();
      test_burst();
      test_pause();
      test_reset_midflight();
      test_empty_swap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule : tb_vc_arbiter
